// File: rtl/lj_frame_fifo.sv
// lj_frame_fifo: stereo frame FIFO from the left-justified ADC receiver to the DAC transmitter.
// It primes before playback, plays silence on underflow and drops frames on overflow.
module lj_frame_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 8,
    parameter int PRIME      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_left,
    input  logic [DATA_WIDTH-1:0]        in_right,
    input  logic                         out_req,
    output logic [DATA_WIDTH-1:0]        out_left,
    output logic [DATA_WIDTH-1:0]        out_right,
    output logic                         out_ack,
    output logic                         out_start,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clear_flags
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic {FILL, RUN} state_t;
    state_t                      state;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [2*DATA_WIDTH-1:0]     mem [DEPTH];
    logic                        pop, push, starve, primed;
    logic [LW-1:0]               level_nxt;
    assign pop       = state == RUN && out_req && level != '0;
    assign starve    = state == RUN && out_req && level == '0;
    // a full FIFO still accepts a frame when the same cycle frees a slot
    assign push      = in_valid && (level != LW'(DEPTH) || pop);
    assign level_nxt = level + LW'(push) - LW'(pop);
    assign primed    = state == FILL && level_nxt >= LW'(PRIME);
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {in_left, in_right};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_left  <= '0;
            out_right <= '0;
            out_ack   <= 1'b0;
            out_start <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_ack   <= out_req;
            out_start <= primed;
            level     <= level_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (out_req) {out_left, out_right} <= pop ? mem[rd_ptr] : '0;
            overflow  <= !clear_flags && (overflow || (in_valid && !push));
            underflow <= !clear_flags && (underflow || starve);
            state     <= primed ? RUN : starve ? FILL : state;
        end
    end
endmodule

// File: tb/tb_lj_frame_fifo.sv
// tb_lj_frame_fifo: table-driven check of priming, ordering, overflow, underflow,
// full push/pop and asynchronous reset of lj_frame_fifo (DEPTH=8, PRIME=4).
module tb_lj_frame_fifo;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_req = 1'b0, clear_flags = 1'b0;
    logic [23:0] in_left = '0, in_right = '0, out_left, out_right;
    logic        out_ack, out_start, overflow, underflow;
    logic [3:0]  level;
    int          n_run = 0, n_fail = 0;

    lj_frame_fifo #(.DATA_WIDTH(24), .DEPTH(8), .PRIME(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_left(in_left), .in_right(in_right),
        .out_req(out_req), .out_left(out_left), .out_right(out_right), .out_ack(out_ack),
        .out_start(out_start), .level(level), .overflow(overflow), .underflow(underflow),
        .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          iv, rq, cf;
        logic [23:0] l;
        logic [3:0]  lvl;
        logic [23:0] el;
        bit          ack, st, ov, un;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(bit iv, int l, bit rq, bit cf, int lvl, int el, bit ack, bit st, bit ov, bit un);
        vec_t r;
        r.iv = iv; r.l = 24'(l); r.rq = rq; r.cf = cf; r.lvl = 4'(lvl); r.el = 24'(el);
        r.ack = ack; r.st = st; r.ov = ov; r.un = un;
        return r;
    endfunction

    function automatic logic [55:0] pack(logic [3:0] lv, logic [23:0] l, logic [23:0] r, bit a, bit s, bit o, bit u);
        return {lv, l, r, a, s, o, u};
    endfunction

    task automatic chk(string name, logic [55:0] got, logic [55:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got lvl=%0d l=%h r=%h ack/st/ov/un=%b, want lvl=%0d l=%h r=%h ack/st/ov/un=%b",
                     name, got[55:52], got[51:28], got[27:4], got[3:0], exp[55:52], exp[51:28], exp[27:4], exp[3:0]);
        end
    endtask

    function automatic logic [55:0] dut_out();
        return pack(level, out_left, out_right, out_ack, out_start, overflow, underflow);
    endfunction

    initial begin
        // priming and ordering
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 1; i <= 4; i++) tbl.push_back(v(1, i, 0, 0, i, 0, 0, i == 4, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 4, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++) tbl.push_back(v(0, 0, 1, 0, 4 - i, i, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4, 0, 0, 0, 0));
        // underflow, sticky flag, clear, refill with second start pulse
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 5; i <= 8; i++) tbl.push_back(v(1, i, 0, 0, i - 4, 0, 0, i == 8, 0, 0));
        // fill to DEPTH, then overflow drops 13 and 14
        for (int i = 9; i <= 12; i++) tbl.push_back(v(1, i, 0, 0, i - 4, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 13, 0, 0, 8, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 14, 0, 1, 8, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 8, 0, 0, 0, 0, 0));
        // push+pop while full, then drain: frame 15 follows 5..12
        tbl.push_back(v(1, 15, 1, 0, 8, 5, 1, 0, 0, 0));
        for (int i = 6; i <= 12; i++) tbl.push_back(v(0, 0, 1, 0, 13 - i, i, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 15, 1, 0, 0, 0));
        // empty RUN with push: no bypass, write stored; clear beats the underflow set
        tbl.push_back(v(1, 16, 1, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(1, 17, 1, 0, 2, 0, 1, 0, 0, 0));

        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom); out_req = 1'($urandom); clear_flags = 1'($urandom);
            in_left = 24'($urandom); in_right = 24'($urandom);
            @(posedge clk); #1;
            chk($sformatf("reset_hold%0d", i), dut_out(), '0);
        end
        in_valid = 0; out_req = 0; clear_flags = 0; in_left = '0; in_right = '0;
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("reset_release", dut_out(), '0);

        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; out_req = tbl[i].rq; clear_flags = tbl[i].cf;
            in_left = tbl[i].l; in_right = ~tbl[i].l;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), dut_out(),
                pack(tbl[i].lvl, tbl[i].el, tbl[i].el == 0 ? 24'h0 : ~tbl[i].el,
                     tbl[i].ack, tbl[i].st, tbl[i].ov, tbl[i].un));
        end

        // asynchronous reset mid-stream, no clock edge needed
        in_valid = 1; out_req = 1; in_left = 24'h18; in_right = ~24'h18;
        @(posedge clk); #1;
        chk("pre_reset_level", {52'(level), 4'b0}, {52'd3, 4'b0});
        #2 rst_n = 1'b0;
        #1 chk("async_reset", dut_out(), '0);
        @(posedge clk); #1;
        chk("reset_hold_mid", dut_out(), '0);
        in_valid = 0; out_req = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", dut_out(), '0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
